// File: rtl/dcache_miss_controller.sv
// L1 data-cache miss sequencer: dirty-victim write-back, line allocate, refill, pipeline stall.
// Optional stall/miss performance counters are built when STALL_PERF_CNT_EN is defined.
module dcache_miss_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             hit_i,
    input  logic             dirty_i,
    input  logic             mem_ack_i,
    output logic             mem_stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             addr_sel_o,
    output logic             refill_we_o
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] stall_cyc_o
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        ALLOC_REQ = 3'd2,
        REFILL    = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic stall;
    logic mreq;
    logic mwe;
    logic asel;
    logic rwe;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only the IDLE stall term looks at the CPU inputs; every other output is Moore.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mreq      = 1'b0;
        mwe       = 1'b0;
        asel      = 1'b0;
        rwe       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i && !hit_i) begin
                    stall     = 1'b1;
                    state_nxt = dirty_i ? WB_REQ : ALLOC_REQ;
                end
            end
            WB_REQ: begin
                stall = 1'b1;
                mreq  = 1'b1;
                mwe   = 1'b1;
                asel  = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = ALLOC_REQ;
                end
            end
            ALLOC_REQ: begin
                stall = 1'b1;
                mreq  = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                stall     = 1'b1;
                rwe       = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset forces outputs low in the same cycle, even while req_i/hit_i would stall.
    assign mem_stall_o = rst_i & stall;
    assign mem_req_o   = rst_i & mreq;
    assign mem_we_o    = rst_i & mwe;
    assign addr_sel_o  = rst_i & asel;
    assign refill_we_o = rst_i & rwe;

`ifdef STALL_PERF_CNT_EN
    logic             miss_start;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] stall_cyc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign miss_start = (state == IDLE) && req_i && !hit_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            miss_cnt  <= '0;
            stall_cyc <= '0;
        end else begin
            if (miss_start) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
            if (stall) begin
                stall_cyc <= sat_inc(stall_cyc);
            end
        end
    end

    assign miss_cnt_o  = miss_cnt;
    assign stall_cyc_o = stall_cyc;
`endif

endmodule
